// File: rtl/result_demux_1x2_nbit_pkg.sv
// Shared definitions for the registered 1-to-2 result demultiplexer:
// the result word width and the per-channel occupancy encoding.
package result_demux_1x2_nbit_pkg;

  localparam int RESULT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/result_demux_1x2_nbit_chan_buf2.sv
// Two-entry output buffer for one demux channel: a head register that
// drives the consumer, a spare register that absorbs one extra word while
// the consumer stalls, and a wrapping count of accepted pushes.
module chan_buf2
  import result_demux_1x2_nbit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop_ready,
  output logic [W-1:0]        head_data,
  output logic                valid,
  output logic                full,
  output logic [RESULT_W-1:0] count
);

  occ_t         state;
  logic [W-1:0] spare;
  logic         pop;

  // Occupancy flags come straight from the registered state so the
  // upstream ready never sees the consumer's ready.
  always_comb begin
    valid = (state != EMPTY);
    full  = (state == TWO);
    pop   = valid & pop_ready;
  end

  // Occupancy FSM with head/spare data movement and the push counter.
  // The head only changes on a pop or when the buffer was empty, so it
  // stays stable while the consumer stalls. Pushes never arrive in TWO
  // because the top holds in_ready low there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      spare     <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        count <= count + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (push) begin
            head_data <= push_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data <= push_data;
          end else if (push) begin
            spare <= push_data;
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_data <= spare;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/result_demux_1x2_nbit.sv
// Registered 1-to-2 result demultiplexer. Channel A carries the add/sub
// result truncated to N bits plus an overflow flag; channel B carries the
// full multiplier result. Each channel buffers up to two words.
module result_demux_1x2_nbit
  import result_demux_1x2_nbit_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RESULT_W-1:0] in_data,
  input  logic                in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        a_data,
  output logic                a_ovf,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [RESULT_W-1:0] b_data,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [RESULT_W-1:0] a_count,
  output logic [RESULT_W-1:0] b_count
);

  logic         a_full;
  logic         b_full;
  logic         push_a;
  logic         push_b;
  logic         in_ovf;
  logic [N:0]   a_head;

  // Overflow marks any dropped upper bits; with a full-width A nothing
  // is dropped so the flag is tied low.
  generate
    if (N < RESULT_W) begin : g_ovf
      assign in_ovf = |in_data[RESULT_W-1:N];
    end else begin : g_no_ovf
      assign in_ovf = 1'b0;
    end
  endgenerate

  // Ready follows the selected channel's fullness; a push goes only to
  // the selected channel so the other one is never disturbed.
  always_comb begin
    in_ready = in_sel ? !b_full : !a_full;
    push_a   = in_valid & in_ready & !in_sel;
    push_b   = in_valid & in_ready & in_sel;
  end

  chan_buf2 #(.W(N + 1)) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data ({in_ovf, in_data[N-1:0]}),
    .pop_ready (a_ready),
    .head_data (a_head),
    .valid     (a_valid),
    .full      (a_full),
    .count     (a_count)
  );

  chan_buf2 #(.W(RESULT_W)) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .pop_ready (b_ready),
    .head_data (b_data),
    .valid     (b_valid),
    .full      (b_full),
    .count     (b_count)
  );

  assign a_data = a_head[N-1:0];
  assign a_ovf  = a_head[N];

endmodule
